arp_responder: RTL and testbench



---
 rtl/arp_responder.sv | 234 +++++++++++++++++++++++
 tb/tb_arp_responder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_responder.sv
// GMII-side ARP responder.
// Parses received Ethernet frames byte by byte, accepts ARP requests aimed at
// MY_IP (broadcast or unicast to MY_MAC), verifies the frame FCS and, after an
// inter-frame gap, sends a 72-byte ARP reply (preamble/SFD, 60-byte body, FCS).
// RX and TX share one clock; only one reply can be pending at a time.
module arp_responder #(
  parameter logic [47:0] MY_MAC = 48'h00301ba0a48e,
  parameter logic [31:0] MY_IP  = 32'h0a00150a,
  parameter int          IFG    = 12
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx_dv,
  input  logic [7:0] rx_data,
  output logic       tx_en,
  output logic [7:0] tx_data,
  output logic       reply_pulse,
  output logic       drop_pulse
);

  typedef enum logic [2:0] {IDLE, RX, DROP, WAIT_IFG, TX} state_t;

  localparam logic [11:0] RX_MIN_LEN  = 12'd72;
  localparam logic [11:0] RX_IDX_MAX  = 12'hFFF;
  localparam logic [6:0]  TX_LEN      = 7'd72;
  localparam logic [7:0]  IFG_LAST    = 8'(IFG - 1);
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_POLY_R  = 32'hEDB88320;  // 04C11DB7 bit-reversed
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;  // in MSB-first bit order

  // Reflected CRC-32 over one byte, data bits taken LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] r;
    r = crc;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY_R;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // The running register is bit-reversed relative to the MSB-first residue.
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31 - i];
    return r;
  endfunction

  // Byte i of a MAC (byte 0 = bits [47:40]) / IPv4 address (byte 0 = bits [31:24]).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input int i);
    return 8'(mac >> (8 * (5 - i)));
  endfunction

  function automatic logic [7:0] ip_byte(input logic [31:0] ip, input int i);
    return 8'(ip >> (8 * (3 - i)));
  endfunction

  // Fixed-value fields of an ARP request for MY_IP; unchecked bytes pass.
  function automatic logic hdr_ok(input int n, input logic [7:0] d);
    logic ok;
    case (n) inside
      [0:6]:      ok = (d == 8'h55);
      7:          ok = (d == 8'hd5);
      20, 24:     ok = (d == 8'h08);
      21, 26:     ok = (d == 8'h06);
      22, 25, 28: ok = (d == 8'h00);
      23, 29:     ok = (d == 8'h01);
      27:         ok = (d == 8'h04);
      [46:49]:    ok = (d == ip_byte(MY_IP, n - 46));
      default:    ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Reply byte k; the FCS bytes are the complemented CRC, LS byte first.
  function automatic logic [7:0] tx_byte(input int k, input logic [47:0] sha_v,
                                         input logic [31:0] spa_v, input logic [31:0] crc);
    logic [31:0] fcs;
    logic [7:0]  b;
    fcs = ~crc;
    case (k) inside
      [0:6]:      b = 8'h55;
      7:          b = 8'hd5;
      [8:13]:     b = mac_byte(sha_v, k - 8);
      [14:19]:    b = mac_byte(MY_MAC, k - 14);
      20, 24:     b = 8'h08;
      21, 26:     b = 8'h06;
      22, 25, 28: b = 8'h00;
      23:         b = 8'h01;
      27:         b = 8'h04;
      29:         b = 8'h02;
      [30:35]:    b = mac_byte(MY_MAC, k - 30);
      [36:39]:    b = ip_byte(MY_IP, k - 36);
      [40:45]:    b = mac_byte(sha_v, k - 40);
      [46:49]:    b = ip_byte(spa_v, k - 46);
      [68:71]:    b = 8'(fcs >> (8 * (k - 68)));
      default:    b = 8'h00;
    endcase
    return b;
  endfunction

  state_t      state;
  logic [11:0] rx_idx;     // bytes of the current frame received so far
  logic [31:0] rx_crc;
  logic        da_bc;      // destination MAC still matches broadcast
  logic        da_uc;      // destination MAC still matches MY_MAC
  logic        rx_dv_q;
  logic [47:0] sha;
  logic [31:0] spa;
  logic [7:0]  ifg_cnt;
  logic [6:0]  tx_idx;     // index of the next reply byte to launch
  logic [31:0] tx_crc;

  logic        rx_start;
  int          cur_idx;
  logic [31:0] crc_base;
  logic [31:0] rx_crc_next;
  logic        bc_next;
  logic        uc_next;
  logic        byte_ok;
  logic        frame_ok;
  logic [7:0]  tx_next;

  // Per-byte RX evaluation and next reply byte.
  always_comb begin
    // NOTE: every combinational output is given a value on every path (defaults
    // first), otherwise synthesis infers a latch.
    rx_start    = rx_dv && !rx_dv_q;
    cur_idx     = (state == IDLE) ? 0 : int'(rx_idx);
    crc_base    = (state == IDLE) ? CRC_INIT : rx_crc;
    bc_next     = (state == IDLE) ? 1'b1 : da_bc;
    uc_next     = (state == IDLE) ? 1'b1 : da_uc;
    rx_crc_next = crc_base;
    if (cur_idx >= 8) rx_crc_next = crc32_byte(crc_base, rx_data);
    if (cur_idx >= 8 && cur_idx <= 13) begin
      bc_next = bc_next && (rx_data == 8'hff);
      uc_next = uc_next && (rx_data == mac_byte(MY_MAC, cur_idx - 8));
    end
    byte_ok  = hdr_ok(cur_idx, rx_data) && (bc_next || uc_next);
    frame_ok = (rx_idx >= RX_MIN_LEN) && (reflect32(rx_crc) == CRC_RESIDUE);
    tx_next  = tx_byte(int'(tx_idx), sha, spa, tx_crc);
  end

  // Frame FSM: parse/verdict on RX, inter-frame gap, then reply transmission.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rx_idx      <= '0;
      rx_crc      <= CRC_INIT;
      da_bc       <= 1'b0;
      da_uc       <= 1'b0;
      rx_dv_q     <= 1'b0;
      sha         <= '0;
      spa         <= '0;
      ifg_cnt     <= '0;
      tx_idx      <= '0;
      tx_crc      <= CRC_INIT;
      tx_en       <= 1'b0;
      tx_data     <= 8'h00;
      reply_pulse <= 1'b0;
      drop_pulse  <= 1'b0;
    end else begin
      // NOTE: registers use non-blocking assignments so every branch below sees
      // the pre-edge values, matching the flop behaviour.
      reply_pulse <= 1'b0;
      drop_pulse  <= 1'b0;
      rx_dv_q     <= rx_dv;
      case (state)
        IDLE: begin
          tx_en   <= 1'b0;
          tx_data <= 8'h00;
          // Only a fresh rising rx_dv starts a frame, so the tail of a frame
          // that began during WAIT_IFG/TX is never parsed.
          if (rx_start) begin
            rx_idx <= 12'd1;
            rx_crc <= rx_crc_next;
            da_bc  <= bc_next;
            da_uc  <= uc_next;
            state  <= byte_ok ? RX : DROP;
          end
        end
        RX: begin
          if (rx_dv) begin
            rx_idx <= (rx_idx == RX_IDX_MAX) ? rx_idx : rx_idx + 12'd1;
            rx_crc <= rx_crc_next;
            da_bc  <= bc_next;
            da_uc  <= uc_next;
            if (cur_idx >= 30 && cur_idx <= 35) sha <= {sha[39:0], rx_data};
            if (cur_idx >= 36 && cur_idx <= 39) spa <= {spa[23:0], rx_data};
            if (!byte_ok) state <= DROP;
          end else if (frame_ok) begin
            reply_pulse <= 1'b1;
            ifg_cnt     <= '0;
            tx_idx      <= '0;
            tx_crc      <= CRC_INIT;
            state       <= WAIT_IFG;
          end else begin
            drop_pulse <= 1'b1;
            state      <= IDLE;
          end
        end
        DROP: begin
          if (!rx_dv) begin
            drop_pulse <= 1'b1;
            state      <= IDLE;
          end
        end
        WAIT_IFG: begin
          if (ifg_cnt == IFG_LAST) begin
            tx_en   <= 1'b1;
            tx_data <= tx_next;
            tx_idx  <= 7'd1;
            state   <= TX;
          end else begin
            ifg_cnt <= ifg_cnt + 8'd1;
          end
        end
        TX: begin
          if (tx_idx == TX_LEN) begin
            tx_en   <= 1'b0;
            tx_data <= 8'h00;
            state   <= IDLE;
          end else begin
            tx_data <= tx_next;
            tx_idx  <= tx_idx + 7'd1;
            if (tx_idx >= 7'd8 && tx_idx < 7'd68) tx_crc <= crc32_byte(tx_crc, tx_next);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arp_responder.sv
// Self-checking bench for arp_responder: expected reply bytes are queued when a
// request is driven and popped by a TX monitor as the DUT transmits.
`timescale 1ns/1ps
module tb_arp_responder;

  localparam logic [47:0] MY_MAC = 48'h00301ba0a48e;
  localparam logic [31:0] MY_IP  = 32'h0a00150a;
  localparam int          IFG    = 12;
  localparam int          TX_LEN = 72;
  localparam logic [47:0] BCAST  = 48'hffffffffffff;
  localparam logic [47:0] SHA_A  = 48'h020000000001;
  localparam logic [31:0] SPA_A  = 32'h0a001501;
  localparam logic [47:0] SHA_B  = 48'h020000000002;
  localparam logic [31:0] SPA_B  = 32'h0a001502;

  typedef logic [7:0] bq_t[$];

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_dv   = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       reply_pulse;
  logic       drop_pulse;

  int  n_checks = 0;
  int  n_fail   = 0;
  bq_t exp_q;
  bq_t tx_buf;
  bit  abort_expected = 1'b0;
  logic [7:0]  mon_exp;
  logic [31:0] mon_res;

  always #4 clock = ~clock;

  arp_responder #(.MY_MAC(MY_MAC), .MY_IP(MY_IP), .IFG(IFG)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx_dv       (rx_dv),
    .rx_data     (rx_data),
    .tx_en       (tx_en),
    .tx_data     (tx_data),
    .reply_pulse (reply_pulse),
    .drop_pulse  (drop_pulse)
  );

  // Ethernet CRC in MSB-first register form, bits fed LSB first per byte.
  function automatic logic [31:0] crc_feed(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0};
      if (fb) r = r ^ 32'h04C11DB7;
    end
    return r;
  endfunction

  function automatic bq_t append_fcs(input bq_t f);
    bq_t         r;
    logic [31:0] c;
    logic [7:0]  b;
    r = f;
    c = 32'hFFFFFFFF;
    for (int i = 8; i < f.size(); i++) c = crc_feed(c, f[i]);
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 8; i++) b[i] = ~c[31 - 8 * j - i];
      r.push_back(b);
    end
    return r;
  endfunction

  function automatic bq_t put_mac(input bq_t f, input logic [47:0] m);
    bq_t r;
    r = f;
    for (int i = 0; i < 6; i++) r.push_back(8'(m >> (8 * (5 - i))));
    return r;
  endfunction

  function automatic bq_t put_ip(input bq_t f, input logic [31:0] a);
    bq_t r;
    r = f;
    for (int i = 0; i < 4; i++) r.push_back(8'(a >> (8 * (3 - i))));
    return r;
  endfunction

  function automatic bq_t build_arp(input logic [47:0] da, input logic [47:0] sa,
                                    input logic [7:0] oper, input logic [47:0] sha,
                                    input logic [31:0] spa, input logic [47:0] tha,
                                    input logic [31:0] tpa);
    bq_t f;
    for (int i = 0; i < 7; i++) f.push_back(8'h55);
    f.push_back(8'hd5);
    f = put_mac(f, da);
    f = put_mac(f, sa);
    f.push_back(8'h08); f.push_back(8'h06); f.push_back(8'h00); f.push_back(8'h01);
    f.push_back(8'h08); f.push_back(8'h00); f.push_back(8'h06); f.push_back(8'h04);
    f.push_back(8'h00); f.push_back(oper);
    f = put_mac(f, sha);
    f = put_ip(f, spa);
    f = put_mac(f, tha);
    f = put_ip(f, tpa);
    while (f.size() < 68) f.push_back(8'h00);
    return append_fcs(f);
  endfunction

  function automatic bq_t build_req(input logic [47:0] da, input logic [47:0] sha,
                                    input logic [31:0] spa, input logic [31:0] tpa);
    return build_arp(da, sha, 8'h01, sha, spa, 48'h0, tpa);
  endfunction

  function automatic bq_t build_reply(input logic [47:0] sha, input logic [31:0] spa);
    return build_arp(sha, MY_MAC, 8'h02, MY_MAC, MY_IP, sha, spa);
  endfunction

  // TX monitor: pops the scoreboard per transmitted byte, checks idle data and,
  // at the end of each frame, its length and FCS residue.
  always @(negedge clock) begin
    if (tx_en) begin
      tx_buf.push_back(tx_data);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL tx_unexpected: got tx_data=%h with no reply pending", tx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (tx_data !== mon_exp) begin
          n_fail++;
          $display("FAIL tx_byte k=%0d: got %h expected %h", tx_buf.size() - 1, tx_data, mon_exp);
        end
      end
    end else begin
      n_checks++;
      if (tx_data !== 8'h00) begin
        n_fail++;
        $display("FAIL tx_idle_data: got %h expected 00", tx_data);
      end
      if (tx_buf.size() > 0) begin
        n_checks++;
        if (abort_expected) begin
          if (tx_buf.size() != 31) begin
            n_fail++;
            $display("FAIL tx_abort_len: got %0d bytes expected 31", tx_buf.size());
          end
          abort_expected = 1'b0;
        end else begin
          if (tx_buf.size() != TX_LEN) begin
            n_fail++;
            $display("FAIL tx_len: got %0d bytes expected %0d", tx_buf.size(), TX_LEN);
          end
          mon_res = 32'hFFFFFFFF;
          for (int i = 8; i < tx_buf.size(); i++) mon_res = crc_feed(mon_res, tx_buf[i]);
          n_checks++;
          if (mon_res !== 32'hC704DD7B) begin
            n_fail++;
            $display("FAIL tx_fcs_residue: got %h expected c704dd7b", mon_res);
          end
        end
        tx_buf.delete();
      end
    end
  end

  // Called at a negedge; returns at the negedge that drops rx_dv (cycle T follows).
  task automatic drive_frame(input bq_t f);
    foreach (f[i]) begin
      rx_dv   = 1'b1;
      rx_data = f[i];
      @(negedge clock);
    end
    rx_dv   = 1'b0;
    rx_data = 8'h00;
  endtask

  // Observation m reflects the DUT state after edge T+m.
  task automatic check_window(input logic exp_reply, input string name);
    logic exp_rp, exp_dp, exp_tx;
    for (int m = 0; m < 200; m++) begin
      @(negedge clock);
      exp_rp = exp_reply && (m == 0);
      exp_dp = !exp_reply && (m == 0);
      exp_tx = exp_reply && (m >= IFG) && (m < IFG + TX_LEN);
      n_checks++;
      if (reply_pulse !== exp_rp) begin
        n_fail++;
        $display("FAIL %s reply_pulse T+%0d: got %b expected %b", name, m, reply_pulse, exp_rp);
      end
      n_checks++;
      if (drop_pulse !== exp_dp) begin
        n_fail++;
        $display("FAIL %s drop_pulse T+%0d: got %b expected %b", name, m, drop_pulse, exp_dp);
      end
      n_checks++;
      if (tx_en !== exp_tx) begin
        n_fail++;
        $display("FAIL %s tx_en T+%0d: got %b expected %b", name, m, tx_en, exp_tx);
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s reply_incomplete: got %0d bytes left expected 0", name, exp_q.size());
    end
  endtask

  task automatic send_and_check(input bq_t f, input logic exp_reply, input logic [47:0] sha,
                                input logic [31:0] spa, input string name);
    bq_t r;
    if (exp_reply) begin
      r = build_reply(sha, spa);
      foreach (r[i]) exp_q.push_back(r[i]);
    end
    drive_frame(f);
    check_window(exp_reply, name);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if (tx_en !== 1'b0) begin n_fail++; $display("FAIL reset_tx_en: got %b expected 0", tx_en); end
    n_checks++;
    if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    n_checks++;
    if (reply_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_reply: got %b expected 0", reply_pulse); end
    n_checks++;
    if (drop_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b expected 0", drop_pulse); end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_broadcast();
    send_and_check(build_req(BCAST, SHA_A, SPA_A, MY_IP), 1'b1, SHA_A, SPA_A, "broadcast");
  endtask

  task automatic test_unicast();
    send_and_check(build_req(MY_MAC, SHA_B, SPA_B, MY_IP), 1'b1, SHA_B, SPA_B, "unicast");
  endtask

  task automatic test_wrong_ip();
    send_and_check(build_req(BCAST, SHA_A, SPA_A, 32'h0a001563), 1'b0, SHA_A, SPA_A, "wrong_ip");
  endtask

  task automatic test_wrong_da();
    send_and_check(build_req(48'h0a0b0c0d0e0f, SHA_A, SPA_A, MY_IP), 1'b0, SHA_A, SPA_A, "wrong_da");
  endtask

  task automatic test_bad_fcs();
    bq_t f;
    f = build_req(BCAST, SHA_A, SPA_A, MY_IP);
    f[40] = f[40] ^ 8'h01;
    send_and_check(f, 1'b0, SHA_A, SPA_A, "bad_fcs");
  endtask

  task automatic test_short_frame();
    bq_t f;
    f = build_req(BCAST, SHA_A, SPA_A, MY_IP);
    while (f.size() > 60) void'(f.pop_back());
    send_and_check(f, 1'b0, SHA_A, SPA_A, "short_frame");
  endtask

  task automatic test_back_to_back();
    bq_t f1, f2, r;
    f1 = build_req(BCAST, SHA_A, SPA_A, MY_IP);
    f2 = build_req(BCAST, SHA_B, SPA_B, MY_IP);
    r  = build_reply(SHA_A, SPA_A);
    foreach (r[i]) exp_q.push_back(r[i]);
    drive_frame(f1);
    fork
      check_window(1'b1, "back_to_back");
      begin
        repeat (4) @(negedge clock);
        drive_frame(f2);
      end
    join
  endtask

  task automatic test_reset_during_tx();
    bq_t r;
    r = build_reply(SHA_A, SPA_A);
    foreach (r[i]) exp_q.push_back(r[i]);
    drive_frame(build_req(BCAST, SHA_A, SPA_A, MY_IP));
    repeat (IFG + 31) @(negedge clock);
    n_checks++;
    if (tx_en !== 1'b1 || tx_data !== r[30]) begin
      n_fail++;
      $display("FAIL abort_k30: got tx_en=%b tx_data=%h expected 1 %h", tx_en, tx_data, r[30]);
    end
    abort_expected = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (tx_en !== 1'b0 || tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_outputs: got tx_en=%b tx_data=%h expected 0 00", tx_en, tx_data);
    end
    repeat (3) @(negedge clock);
    exp_q.delete();
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    send_and_check(build_req(BCAST, SHA_B, SPA_B, MY_IP), 1'b1, SHA_B, SPA_B, "after_abort");
  endtask

  initial begin
    test_reset();
    test_broadcast();
    test_wrong_ip();
    test_bad_fcs();
    test_back_to_back();
    test_reset_during_tx();
    test_short_frame();
    test_unicast();
    test_wrong_da();
    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
